// File: rtl/ysyx_22041211_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter in front of the unified SRAM.
// One transaction in flight; the owner's channels are muxed combinationally onto the slave port.
module ysyx_22041211_axi_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic [ADDR_LEN-1:0]   ifu_ar_addr_i,
    input  logic                  ifu_ar_valid_i,
    output logic                  ifu_ar_ready_o,
    output logic [DATA_LEN-1:0]   ifu_r_data_o,
    output logic [1:0]            ifu_r_resp_o,
    output logic                  ifu_r_valid_o,
    input  logic                  ifu_r_ready_i,

    input  logic [ADDR_LEN-1:0]   lsu_ar_addr_i,
    input  logic                  lsu_ar_valid_i,
    output logic                  lsu_ar_ready_o,
    output logic [DATA_LEN-1:0]   lsu_r_data_o,
    output logic [1:0]            lsu_r_resp_o,
    output logic                  lsu_r_valid_o,
    input  logic                  lsu_r_ready_i,
    input  logic [ADDR_LEN-1:0]   lsu_aw_addr_i,
    input  logic                  lsu_aw_valid_i,
    output logic                  lsu_aw_ready_o,
    input  logic [DATA_LEN-1:0]   lsu_w_data_i,
    input  logic [DATA_LEN/8-1:0] lsu_w_strb_i,
    input  logic                  lsu_w_valid_i,
    output logic                  lsu_w_ready_o,
    output logic [1:0]            lsu_b_resp_o,
    output logic                  lsu_b_valid_o,
    input  logic                  lsu_b_ready_i,

    output logic [ADDR_LEN-1:0]   s_ar_addr_o,
    output logic                  s_ar_valid_o,
    input  logic                  s_ar_ready_i,
    input  logic [DATA_LEN-1:0]   s_r_data_i,
    input  logic [1:0]            s_r_resp_i,
    input  logic                  s_r_valid_i,
    output logic                  s_r_ready_o,
    output logic [ADDR_LEN-1:0]   s_aw_addr_o,
    output logic                  s_aw_valid_o,
    input  logic                  s_aw_ready_i,
    output logic [DATA_LEN-1:0]   s_w_data_o,
    output logic [DATA_LEN/8-1:0] s_w_strb_o,
    output logic                  s_w_valid_o,
    input  logic                  s_w_ready_i,
    input  logic [1:0]            s_b_resp_i,
    input  logic                  s_b_valid_i,
    output logic                  s_b_ready_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_t;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    state_t r_state;
    logic   r_last_grant;

    logic w_ifu_req;
    logic w_lsu_req;
    logic w_grant_lsu;
    logic w_ifu_own;
    logic w_lsu_rd_own;
    logic w_lsu_wr_own;

    assign w_ifu_req   = ifu_ar_valid_i;
    assign w_lsu_req   = lsu_aw_valid_i | lsu_ar_valid_i;
    // Under contention the master that did not win last time goes first.
    assign w_grant_lsu = w_lsu_req & (~w_ifu_req | (r_last_grant == GRANT_IFU));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_LSU;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_lsu) begin
                        r_state      <= lsu_aw_valid_i ? LSU_WR : LSU_RD;
                        r_last_grant <= GRANT_LSU;
                    end else if (w_ifu_req) begin
                        r_state      <= IFU_RD;
                        r_last_grant <= GRANT_IFU;
                    end
                end
                IFU_RD: if (s_r_valid_i & ifu_r_ready_i) r_state <= IDLE;
                LSU_RD: if (s_r_valid_i & lsu_r_ready_i) r_state <= IDLE;
                LSU_WR: if (s_b_valid_i & lsu_b_ready_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_ifu_own    = (r_state == IFU_RD);
    assign w_lsu_rd_own = (r_state == LSU_RD);
    assign w_lsu_wr_own = (r_state == LSU_WR);

    // Read path: slave AR/R follow whichever master owns the read.
    assign s_ar_addr_o  = w_ifu_own ? ifu_ar_addr_i : (w_lsu_rd_own ? lsu_ar_addr_i : '0);
    assign s_ar_valid_o = (w_ifu_own & ifu_ar_valid_i) | (w_lsu_rd_own & lsu_ar_valid_i);
    assign s_r_ready_o  = (w_ifu_own & ifu_r_ready_i)  | (w_lsu_rd_own & lsu_r_ready_i);

    assign ifu_ar_ready_o = w_ifu_own & s_ar_ready_i;
    assign ifu_r_valid_o  = w_ifu_own & s_r_valid_i;
    assign ifu_r_data_o   = w_ifu_own ? s_r_data_i : '0;
    assign ifu_r_resp_o   = w_ifu_own ? s_r_resp_i : 2'b00;

    assign lsu_ar_ready_o = w_lsu_rd_own & s_ar_ready_i;
    assign lsu_r_valid_o  = w_lsu_rd_own & s_r_valid_i;
    assign lsu_r_data_o   = w_lsu_rd_own ? s_r_data_i : '0;
    assign lsu_r_resp_o   = w_lsu_rd_own ? s_r_resp_i : 2'b00;

    // Write path: AW and W handshake independently; B closes the transaction.
    assign s_aw_addr_o  = w_lsu_wr_own ? lsu_aw_addr_i : '0;
    assign s_aw_valid_o = w_lsu_wr_own & lsu_aw_valid_i;
    assign s_w_data_o   = w_lsu_wr_own ? lsu_w_data_i : '0;
    assign s_w_strb_o   = w_lsu_wr_own ? lsu_w_strb_i : '0;
    assign s_w_valid_o  = w_lsu_wr_own & lsu_w_valid_i;
    assign s_b_ready_o  = w_lsu_wr_own & lsu_b_ready_i;

    assign lsu_aw_ready_o = w_lsu_wr_own & s_aw_ready_i;
    assign lsu_w_ready_o  = w_lsu_wr_own & s_w_ready_i;
    assign lsu_b_valid_o  = w_lsu_wr_own & s_b_valid_i;
    assign lsu_b_resp_o   = w_lsu_wr_own ? s_b_resp_i : 2'b00;

endmodule

// File: tb/tb_ysyx_22041211_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI-Lite arbiter: an ownership model checks every output each cycle,
// and literal expectations pin grant order, forwarded payloads and reset behaviour.
module tb_ysyx_22041211_axi_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ifu_ar_addr_i;
    logic        ifu_ar_valid_i, ifu_r_ready_i;
    logic        ifu_ar_ready_o, ifu_r_valid_o;
    logic [31:0] ifu_r_data_o;
    logic [1:0]  ifu_r_resp_o;
    logic [31:0] lsu_ar_addr_i, lsu_aw_addr_i, lsu_w_data_i;
    logic [3:0]  lsu_w_strb_i;
    logic        lsu_ar_valid_i, lsu_r_ready_i, lsu_aw_valid_i, lsu_w_valid_i, lsu_b_ready_i;
    logic        lsu_ar_ready_o, lsu_r_valid_o, lsu_aw_ready_o, lsu_w_ready_o, lsu_b_valid_o;
    logic [31:0] lsu_r_data_o;
    logic [1:0]  lsu_r_resp_o, lsu_b_resp_o;
    logic [31:0] s_ar_addr_o, s_aw_addr_o, s_w_data_o, s_r_data_i;
    logic [3:0]  s_w_strb_o;
    logic        s_ar_valid_o, s_r_ready_o, s_aw_valid_o, s_w_valid_o, s_b_ready_o;
    logic        s_ar_ready_i, s_r_valid_i, s_aw_ready_i, s_w_ready_i, s_b_valid_i;
    logic [1:0]  s_r_resp_i, s_b_resp_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22041211_axi_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .ifu_ar_addr_i(ifu_ar_addr_i), .ifu_ar_valid_i(ifu_ar_valid_i), .ifu_ar_ready_o(ifu_ar_ready_o),
        .ifu_r_data_o(ifu_r_data_o), .ifu_r_resp_o(ifu_r_resp_o), .ifu_r_valid_o(ifu_r_valid_o),
        .ifu_r_ready_i(ifu_r_ready_i),
        .lsu_ar_addr_i(lsu_ar_addr_i), .lsu_ar_valid_i(lsu_ar_valid_i), .lsu_ar_ready_o(lsu_ar_ready_o),
        .lsu_r_data_o(lsu_r_data_o), .lsu_r_resp_o(lsu_r_resp_o), .lsu_r_valid_o(lsu_r_valid_o),
        .lsu_r_ready_i(lsu_r_ready_i),
        .lsu_aw_addr_i(lsu_aw_addr_i), .lsu_aw_valid_i(lsu_aw_valid_i), .lsu_aw_ready_o(lsu_aw_ready_o),
        .lsu_w_data_i(lsu_w_data_i), .lsu_w_strb_i(lsu_w_strb_i), .lsu_w_valid_i(lsu_w_valid_i),
        .lsu_w_ready_o(lsu_w_ready_o),
        .lsu_b_resp_o(lsu_b_resp_o), .lsu_b_valid_o(lsu_b_valid_o), .lsu_b_ready_i(lsu_b_ready_i),
        .s_ar_addr_o(s_ar_addr_o), .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready_i),
        .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i), .s_r_valid_i(s_r_valid_i), .s_r_ready_o(s_r_ready_o),
        .s_aw_addr_o(s_aw_addr_o), .s_aw_valid_o(s_aw_valid_o), .s_aw_ready_i(s_aw_ready_i),
        .s_w_data_o(s_w_data_o), .s_w_strb_o(s_w_strb_o), .s_w_valid_o(s_w_valid_o), .s_w_ready_i(s_w_ready_i),
        .s_b_resp_i(s_b_resp_i), .s_b_valid_i(s_b_valid_i), .s_b_ready_o(s_b_ready_o)
    );

    task automatic lit(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- ownership model ----------------
    localparam int NONE = 0, M_IFU = 1, M_LSU_R = 2, M_LSU_W = 3;
    int m_owner = NONE;
    int m_last  = 1;   // 0 = IFU served last, 1 = LSU served last

    function automatic int pick_owner(logic i_req, logic l_wr, logic l_rd, int last);
        if (i_req && (l_wr || l_rd)) return (last == 1) ? M_IFU : (l_wr ? M_LSU_W : M_LSU_R);
        if (l_wr)  return M_LSU_W;
        if (l_rd)  return M_LSU_R;
        if (i_req) return M_IFU;
        return NONE;
    endfunction

    function automatic logic owner_done(int owner);
        case (owner)
            M_IFU:   return s_r_valid_i & ifu_r_ready_i;
            M_LSU_R: return s_r_valid_i & lsu_r_ready_i;
            M_LSU_W: return s_b_valid_i & lsu_b_ready_i;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_owner <= NONE;
            m_last  <= 1;
        end else if (m_owner == NONE) begin
            m_owner <= pick_owner(ifu_ar_valid_i, lsu_aw_valid_i, lsu_ar_valid_i, m_last);
            if (pick_owner(ifu_ar_valid_i, lsu_aw_valid_i, lsu_ar_valid_i, m_last) == M_IFU) m_last <= 0;
            else if (pick_owner(ifu_ar_valid_i, lsu_aw_valid_i, lsu_ar_valid_i, m_last) != NONE) m_last <= 1;
        end else if (owner_done(m_owner)) begin
            m_owner <= NONE;
        end
    end

    function automatic logic [255:0] exp_ifu();
        if (m_owner == M_IFU) return {s_ar_ready_i, s_r_valid_i, s_r_resp_i, s_r_data_i};
        return '0;
    endfunction

    function automatic logic [255:0] exp_lsu();
        if (m_owner == M_LSU_R) return {s_ar_ready_i, s_r_valid_i, s_r_resp_i, s_r_data_i, 5'b0};
        if (m_owner == M_LSU_W) return {36'b0, s_aw_ready_i, s_w_ready_i, s_b_valid_i, s_b_resp_i};
        return '0;
    endfunction

    function automatic logic [255:0] exp_srd();
        if (m_owner == M_IFU)   return {ifu_ar_valid_i, ifu_ar_addr_i, ifu_r_ready_i};
        if (m_owner == M_LSU_R) return {lsu_ar_valid_i, lsu_ar_addr_i, lsu_r_ready_i};
        return '0;
    endfunction

    function automatic logic [255:0] exp_swr();
        if (m_owner == M_LSU_W)
            return {lsu_aw_valid_i, lsu_aw_addr_i, lsu_w_valid_i, lsu_w_data_i, lsu_w_strb_i, lsu_b_ready_i};
        return '0;
    endfunction

    always @(negedge clk) begin
        lit("cyc_ifu", {ifu_ar_ready_o, ifu_r_valid_o, ifu_r_resp_o, ifu_r_data_o}, exp_ifu());
        lit("cyc_lsu", {lsu_ar_ready_o, lsu_r_valid_o, lsu_r_resp_o, lsu_r_data_o,
                        lsu_aw_ready_o, lsu_w_ready_o, lsu_b_valid_o, lsu_b_resp_o}, exp_lsu());
        lit("cyc_srd", {s_ar_valid_o, s_ar_addr_o, s_r_ready_o}, exp_srd());
        lit("cyc_swr", {s_aw_valid_o, s_aw_addr_o, s_w_valid_o, s_w_data_o, s_w_strb_o, s_b_ready_o}, exp_swr());
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] all_outputs();
        return {ifu_ar_ready_o, ifu_r_valid_o, ifu_r_resp_o, ifu_r_data_o,
                lsu_ar_ready_o, lsu_r_valid_o, lsu_r_resp_o, lsu_r_data_o,
                lsu_aw_ready_o, lsu_w_ready_o, lsu_b_valid_o, lsu_b_resp_o,
                s_ar_valid_o, s_ar_addr_o, s_r_ready_o,
                s_aw_valid_o, s_aw_addr_o, s_w_valid_o, s_w_data_o, s_w_strb_o, s_b_ready_o};
    endfunction

    // Acts as the slave for one read; the master seen on AR is retired after its handshake.
    task automatic serve_rd(input string nm, input logic [31:0] exp_addr, input logic [31:0] rdata, input int lat);
        int   n;
        logic by_ifu;
        s_ar_ready_i = 1'b1;
        #1;
        n = 0;
        while (!s_ar_valid_o && n < 20) begin tick; #1; n++; end
        lit({nm, "_ar"}, {s_ar_valid_o, s_ar_addr_o}, {1'b1, exp_addr});
        by_ifu = ifu_ar_ready_o;
        tick;
        s_ar_ready_i = 1'b0;
        if (by_ifu) ifu_ar_valid_i = 1'b0; else lsu_ar_valid_i = 1'b0;
        repeat (lat) tick;
        s_r_valid_i = 1'b1;
        s_r_data_i  = rdata;
        s_r_resp_i  = 2'b00;
        #1;
        n = 0;
        while (!s_r_ready_o && n < 20) begin tick; #1; n++; end
        lit({nm, "_r"}, by_ifu ? {ifu_r_valid_o, ifu_r_data_o} : {lsu_r_valid_o, lsu_r_data_o}, {1'b1, rdata});
        tick;
        s_r_valid_i = 1'b0;
        s_r_data_i  = '0;
    endtask

    task automatic serve_wr(input string nm, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                            input logic [3:0] exp_strb);
        int n;
        s_aw_ready_i = 1'b1;
        s_w_ready_i  = 1'b1;
        #1;
        n = 0;
        while (!s_aw_valid_o && n < 20) begin tick; #1; n++; end
        lit({nm, "_aw_w"}, {s_aw_valid_o, s_aw_addr_o, s_w_valid_o, s_w_data_o, s_w_strb_o},
            {1'b1, exp_addr, 1'b1, exp_data, exp_strb});
        lit({nm, "_ifu_blocked"}, {ifu_ar_ready_o, lsu_ar_ready_o}, 256'd0);
        tick;
        s_aw_ready_i   = 1'b0;
        s_w_ready_i    = 1'b0;
        lsu_aw_valid_i = 1'b0;
        lsu_w_valid_i  = 1'b0;
        s_b_valid_i    = 1'b1;
        s_b_resp_i     = 2'b00;
        #1;
        lit({nm, "_b"}, {lsu_b_valid_o, lsu_b_resp_o, s_b_ready_o}, {1'b1, 2'b00, 1'b1});
        tick;
        s_b_valid_i = 1'b0;
        #1;
        lit({nm, "_idle"}, {lsu_b_valid_o, lsu_aw_ready_o, s_aw_valid_o}, 256'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn = 1'b0;
        ifu_ar_addr_i = '0; ifu_ar_valid_i = 1'b0; ifu_r_ready_i = 1'b1;
        lsu_ar_addr_i = '0; lsu_ar_valid_i = 1'b0; lsu_r_ready_i = 1'b1;
        lsu_aw_addr_i = '0; lsu_aw_valid_i = 1'b0; lsu_w_data_i = '0; lsu_w_strb_i = '0;
        lsu_w_valid_i = 1'b0; lsu_b_ready_i = 1'b1;
        s_ar_ready_i = 1'b0; s_r_data_i = '0; s_r_resp_i = '0; s_r_valid_i = 1'b0;
        s_aw_ready_i = 1'b0; s_w_ready_i = 1'b0; s_b_resp_i = '0; s_b_valid_i = 1'b0;
        #1;
        lit("reset_all_zero", all_outputs(), 256'd0);
        tick; tick;
        rstn = 1'b1;
        tick;

        // IFU alone: one-cycle bubble, then AR forwarded; data comes back 2 cycles after AR.
        ifu_ar_addr_i  = 32'h8000_0000;
        ifu_ar_valid_i = 1'b1;
        #1;
        lit("t1_idle_bubble", {ifu_ar_ready_o, s_ar_valid_o}, 256'd0);
        serve_rd("t1_ifu", 32'h8000_0000, 32'h0010_0073, 1);
        #1;
        lit("t1_back_idle", {ifu_r_valid_o, s_r_ready_o}, 256'd0);

        // LSU write with W presented one cycle ahead of AW.
        tick;
        lsu_w_data_i  = 32'hDEAD_BEEF;
        lsu_w_strb_i  = 4'hF;
        lsu_w_valid_i = 1'b1;
        s_w_ready_i   = 1'b1;
        #1;
        lit("t2_w_early_blocked", {lsu_w_ready_o, s_w_valid_o}, 256'd0);
        tick;
        lsu_aw_addr_i  = 32'h8000_1000;
        lsu_aw_valid_i = 1'b1;
        serve_wr("t2_wr", 32'h8000_1000, 32'hDEAD_BEEF, 4'hF);

        // Contention straight after reset: IFU first; IFU re-requests at once, so LSU goes next.
        tick;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        tick;
        ifu_ar_addr_i  = 32'h8000_0100; ifu_ar_valid_i = 1'b1;
        lsu_ar_addr_i  = 32'h8000_2000; lsu_ar_valid_i = 1'b1;
        serve_rd("t3_first_ifu", 32'h8000_0100, 32'h1111_1111, 0);
        ifu_ar_addr_i  = 32'h8000_0104; ifu_ar_valid_i = 1'b1;
        serve_rd("t3_then_lsu", 32'h8000_2000, 32'h2222_2222, 0);
        serve_rd("t3_then_ifu", 32'h8000_0104, 32'h3333_3333, 0);

        // LSU write + LSU read + IFU read together: write first, then round-robin on the reads.
        tick;
        ifu_ar_addr_i  = 32'h8000_0200; ifu_ar_valid_i = 1'b1;
        lsu_ar_addr_i  = 32'h8000_3000; lsu_ar_valid_i = 1'b1;
        lsu_aw_addr_i  = 32'h8000_3004; lsu_aw_valid_i = 1'b1;
        lsu_w_data_i   = 32'h0BAD_F00D; lsu_w_strb_i = 4'h5; lsu_w_valid_i = 1'b1;
        serve_wr("t4_wr_first", 32'h8000_3004, 32'h0BAD_F00D, 4'h5);
        serve_rd("t4_ifu_second", 32'h8000_0200, 32'h4444_4444, 0);
        serve_rd("t4_lsu_third", 32'h8000_3000, 32'h5555_5555, 0);

        // Backpressure: IFU holds off R for 3 cycles while the LSU waits.
        tick;
        ifu_r_ready_i  = 1'b0;
        ifu_ar_addr_i  = 32'h8000_0300; ifu_ar_valid_i = 1'b1;
        lsu_ar_addr_i  = 32'h8000_4000; lsu_ar_valid_i = 1'b1;
        s_ar_ready_i   = 1'b1;
        #1;
        for (int n = 0; n < 20 && !s_ar_valid_o; n++) begin tick; #1; end
        lit("t5_ifu_granted", {ifu_ar_ready_o, s_ar_addr_o}, {1'b1, 32'h8000_0300});
        tick;
        ifu_ar_valid_i = 1'b0;
        s_r_valid_i    = 1'b1;
        s_r_data_i     = 32'h6666_6666;
        for (int i = 0; i < 3; i++) begin
            #1;
            lit("t5_hold", {ifu_r_valid_o, ifu_r_data_o, lsu_ar_ready_o, s_r_ready_o},
                {1'b1, 32'h6666_6666, 1'b0, 1'b0});
            tick;
        end
        ifu_r_ready_i = 1'b1;
        s_ar_ready_i  = 1'b0;
        tick;
        s_r_valid_i = 1'b0;
        s_r_data_i  = '0;
        serve_rd("t5_lsu_after", 32'h8000_4000, 32'h7777_7777, 0);

        // Asynchronous reset in LSU_WR after AW handshake, W still pending.
        tick;
        lsu_aw_addr_i  = 32'h8000_5000; lsu_aw_valid_i = 1'b1;
        lsu_w_data_i   = 32'hCAFE_0001; lsu_w_strb_i = 4'h3; lsu_w_valid_i = 1'b1;
        s_aw_ready_i   = 1'b1;
        #1;
        for (int n = 0; n < 20 && !s_aw_valid_o; n++) begin tick; #1; end
        lit("t6_aw_fwd", {s_aw_valid_o, s_aw_addr_o}, {1'b1, 32'h8000_5000});
        tick;
        lsu_aw_valid_i = 1'b0;
        s_aw_ready_i   = 1'b0;
        #1;
        lit("t6_w_pending", {s_w_valid_o, s_w_data_o}, {1'b1, 32'hCAFE_0001});
        #1;
        rstn = 1'b0;
        #1;
        lit("t6_async_zero", all_outputs(), 256'd0);
        tick;
        rstn = 1'b1;
        s_w_ready_i = 1'b1;
        #1;
        lit("t6_idle_after", {lsu_w_ready_o, s_w_valid_o}, 256'd0);
        tick;
        lsu_w_valid_i = 1'b0;
        s_w_ready_i   = 1'b0;
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: sequence still running at %0t, limit 100000", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_axi_arbiter.md
Name: ysyx_22041211_axi_arbiter

Overview:
- Two-master, one-slave AXI4-Lite arbiter placed directly upstream of a single unified AXI SRAM.
- It replaces the current split instruction and data SRAM instances.
- Master 0 is the IFU port (read-only). Master 1 is the LSU port (read and write).
- Exactly one transaction is outstanding at a time. Ownership is held until the response handshake completes.

Parameters:
- ADDR_LEN, 32, address width of all AR/AW channels.
- DATA_LEN, 32, data width of R/W channels; strobe width is DATA_LEN/8.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- ifu_ar_addr_i / ifu_ar_valid_i / ifu_ar_ready_o  in/in/out  ADDR_LEN/1/1  IFU read address channel.
- ifu_r_data_o / ifu_r_resp_o / ifu_r_valid_o / ifu_r_ready_i  out/out/out/in  DATA_LEN/2/1/1  IFU read data channel.
- lsu_ar_addr_i / lsu_ar_valid_i / lsu_ar_ready_o  in/in/out  ADDR_LEN/1/1  LSU read address channel.
- lsu_r_data_o / lsu_r_resp_o / lsu_r_valid_o / lsu_r_ready_i  out/out/out/in  DATA_LEN/2/1/1  LSU read data channel.
- lsu_aw_addr_i / lsu_aw_valid_i / lsu_aw_ready_o  in/in/out  ADDR_LEN/1/1  LSU write address channel.
- lsu_w_data_i / lsu_w_strb_i / lsu_w_valid_i / lsu_w_ready_o  in/in/in/out  DATA_LEN/DATA_LEN/8/1/1  LSU write data channel.
- lsu_b_resp_o / lsu_b_valid_o / lsu_b_ready_i  out/out/in  2/1/1  LSU write response channel.
- s_ar_addr_o / s_ar_valid_o / s_ar_ready_i  out/out/in  ADDR_LEN/1/1  slave read address channel.
- s_r_data_i / s_r_resp_i / s_r_valid_i / s_r_ready_o  in/in/in/out  DATA_LEN/2/1/1  slave read data channel.
- s_aw_addr_o / s_aw_valid_o / s_aw_ready_i  out/out/in  ADDR_LEN/1/1  slave write address channel.
- s_w_data_o / s_w_strb_o / s_w_valid_o / s_w_ready_i  out/out/out/in  DATA_LEN/DATA_LEN/8/1/1  slave write data channel.
- s_b_resp_i / s_b_valid_i / s_b_ready_o  in/in/out  2/1/1  slave write response channel.

Behaviour:
- Reset:
  - Asynchronous assertion when rstn=0. FSM goes to IDLE and last_grant goes to LSU.
  - Every output is 0: all valids, all readys, addr, data, strb, resp.
  - Reset mid-transaction abandons the transaction. Masters must re-issue after release.
- State registers: state in {IDLE, IFU_RD, LSU_RD, LSU_WR}; last_grant (1 bit).
- IDLE:
  - All slave valids are 0 and all master readys/valids are 0; only requests are sampled.
  - LSU request = lsu_aw_valid_i | lsu_ar_valid_i. If the LSU has both, the write wins (LSU_WR).
  - If IFU and LSU both request, grant the one not equal to last_grant (round-robin). A single requester is granted directly.
  - The granted state is entered on the next edge and last_grant is updated. This gives a fixed 1-cycle arbitration bubble.
- IFU_RD and LSU_RD:
  - The owner's AR and R channels are wired combinationally to s_ar_* and s_r_*.
  - The non-owner sees ar_ready=0 and r_valid=0, with its r_data/r_resp forced to 0.
  - s_aw_valid_o and s_w_valid_o are 0; s_b_ready_o is 0.
  - Return to IDLE on the edge where s_r_valid_i & owner r_ready_i.
- LSU_WR:
  - AW and W are forwarded independently (either order, or the same cycle). The B channel is forwarded.
  - All read-side slave valids/readys are 0.
  - Return to IDLE on the edge where s_b_valid_i & lsu_b_ready_i.
- Slave resp codes are passed through unmodified. The arbiter generates no errors.
- The arbiter relies on masters holding valid and payload stable until ready; it does not register payloads.
- A valid dropped by a master in IDLE before grant is not an error: re-evaluate every IDLE cycle.
- A request arriving in the same cycle the FSM returns to IDLE is arbitrated in the following IDLE cycle. Minimum spacing between grants is therefore 2 cycles after the final handshake.

Test Plan:
- IFU only: ifu_ar_addr=0x80000000, slave returns 0x00100073 after 2 cycles -> the IFU sees r_valid with data 0x00100073. State goes IDLE->IFU_RD->IDLE and LSU outputs stay 0.
- LSU write: aw_addr=0x80001000, w_data=0xDEADBEEF, strb=0xF, with W presented 1 cycle before AW -> the slave sees both. lsu_b_valid is forwarded with resp=0, then the FSM returns to IDLE.
- Contention: IFU and LSU read requests asserted in the same cycle after reset (last_grant=LSU) -> the IFU is served first, then the LSU. The next simultaneous pair serves the LSU first.
- LSU has aw_valid and ar_valid plus the IFU reads, all together -> the LSU write completes before either read. The IFU ar_ready stays 0 throughout.
- Backpressure: the slave holds s_r_valid while ifu_r_ready=0 for 3 cycles -> the grant is held and the LSU request is not granted until the handshake completes.
- Reset mid-op: rstn=0 asynchronously during LSU_WR, after AW accepted but before B -> all outputs are 0 immediately and the state is IDLE after release.
